openhmc_axis_link_monitor: RTL and testbench
============================================

// Module: openhmc_axis_link_monitor
// PURPOSE
// Synthesizable, multi-channel protocol monitor for openHMC AXI4-Stream flit interfaces (TX and RX sides, any mix).
// Passively observes NUM_CH streams and tracks handshake legality, stall duration and packet framing from TUSER.
// Keeps saturating flit/packet counters per channel and raises sticky error flags. Never drives the monitored bus.
// Sits beside the controller top and feeds a debug RF or ILA. Also usable as a bench-side checker.
// PARAMETERS
// NUM_CH           2        number of monitored streams, 1..8
// FPW              4        flits per word, legal 2,4,6,8
// DWIDTH           FPW*128  TDATA width per channel
// NUM_DATA_BYTES   FPW*16   TUSER width per channel
//                           bits [FPW-1:0]=valid, [2FPW-1:FPW]=hdr, [3FPW-1:2FPW]=tail
// STALL_LIMIT_LOG  10       stall timeout = 2**STALL_LIMIT_LOG consecutive stalled cycles
// CNT_W            32       width of each flit/packet counter
// PORTS
// clk_hmc      in   1                   monitor clock; all streams synchronous to it
// res_n_hmc    in   1                   asynchronous active-low reset
// mon_enable   in   1                   1 = capture errors and count; 0 = freeze counters/errors, tracking continues
// mon_clear    in   1                   sync pulse: zero all counters and sticky errors
// ch_tvalid    in   NUM_CH              TVALID per channel
// ch_tready    in   NUM_CH              TREADY per channel
// ch_tdata     in   NUM_CH*DWIDTH       TDATA, channel c at [c*DWIDTH +: DWIDTH]
// ch_tuser     in   NUM_CH*NUM_DATA_BYTES  TUSER, channel c at [c*NUM_DATA_BYTES +: NUM_DATA_BYTES]
// err_sticky   out  NUM_CH*4            per channel {FRAMING,STALL_TO,DATA_UNSTABLE,VALID_DROP}, channel c at [c*4 +: 4]
// err_any      out  1                   registered OR of all err_sticky bits
// flit_cnt     out  NUM_CH*CNT_W        accepted valid flits per channel
// pkt_cnt      out  NUM_CH*CNT_W        accepted tail flits (completed packets) per channel
// pkt_open     out  NUM_CH              1 = channel currently inside a packet (hdr seen, tail not yet)
// BEHAVIOUR
// - Reset: all outputs 0. Stall FSM = IDLE, pkt state = CLOSED, stall counter = 0, capture regs = 0.
// - Handshake (hs) = tvalid & tready. All outputs are registered, 1-cycle latency from the sampled edge.
// - Stall FSM per channel, IDLE/STALLED:
//   - IDLE -> STALLED on tvalid & !tready. Capture tdata/tuser and clear stall counter.
//   - STALLED -> IDLE on hs.
//   - STALLED -> IDLE on !tvalid. This raises VALID_DROP.
//   - In STALLED, tdata or tuser != capture raises DATA_UNSTABLE. The FSM stays in STALLED and re-captures.
//   - The stall counter increments each STALLED cycle and saturates.
//   - When the counter reaches 2**STALL_LIMIT_LOG-1, STALL_TO is raised once per stall episode.
// - Framing, evaluated only on hs, flit 0..FPW-1 in order, flits with valid=0 skipped.
//   - CLOSED:
//     - hdr&tail = legal single-flit packet, stay CLOSED.
//     - hdr only -> OPEN.
//     - tail only, or neither = FRAMING error, stay CLOSED.
//   - OPEN:
//     - hdr = FRAMING error; state becomes OPEN if tail=0, else CLOSED.
//     - tail only -> CLOSED.
//     - neither = continue.
//   - Multiple packets per beat are legal.
// - Counters on hs with mon_enable=1:
//   - flit_cnt += popcount(valid).
//   - pkt_cnt += popcount(valid&tail).
//   - Both saturate at all-ones and never wrap.
// - Errors are sticky until mon_clear or reset. They are set only while mon_enable=1.
// - mon_clear zeroes counters and errors. It does not touch FSM or pkt state, so a mid-packet clear gives no false FRAMING.
// - mon_clear and an increment/error in the same cycle: clear wins; that event is lost.
// - Reset asserted mid-packet or mid-stall returns to the reset state immediately. No error is flagged on release.
// - Channels are fully independent; NUM_CH=1 is legal.
// STRUCTURE
// - Package openhmc_mon_pkg:
//   - err index constants ERR_VALID_DROP=0, ERR_DATA_UNSTABLE=1, ERR_STALL_TO=2, ERR_FRAMING=3.
//   - typedef stall_state_t {IDLE,STALLED}.
//   - typedef pkt_state_t {CLOSED,OPEN}.
//   - TUSER field offset functions.
// - Sub-module openhmc_axis_ch_monitor: one channel (FSM, framing, counters). Instantiated NUM_CH times in a generate loop.
// - The top-level body is slicing plus the err_any reduction register.
// TESTING
// 1 Reset, then 8 hs beats, FPW=4, valid=4'hF, hdr=4'h1, tail=4'h8 -> flit_cnt=32, pkt_cnt=8, err_sticky=0, pkt_open=0.
// 2 tvalid=1, tready=0 for 3 cycles, then tvalid=0 -> VALID_DROP=1 and err_any=1 one cycle later; counts unchanged.
// 3 Stall with tdata bit0 toggled in the 2nd stall cycle -> DATA_UNSTABLE=1 only.
//   Then stall 1024 cycles (STALL_LIMIT_LOG=10) -> STALL_TO=1.
// 4 Beat valid=F, hdr=4'b0101, tail=4'b1010 -> 2 packets, no error.
//   Then beat valid=F, hdr=0, tail=0 -> FRAMING=1.
// 5 Beat with hdr only (pkt_open=1), mon_clear, then tail beat -> counters 0 before, pkt_cnt=1 after, no FRAMING.
// 6 Drive ch0 errors with ch1 clean, NUM_CH=2 -> only err_sticky[3:0] set.
//   Then assert mon_clear together with an hs -> all 0 afterwards.

Source files
------------

// File: rtl/openhmc_mon_pkg.sv
// Shared types and constants for the openHMC AXI4-Stream link monitor.
// Error bit indices and TUSER field offsets are used by both the channel monitor and its users.
package openhmc_mon_pkg;

  localparam int ERR_VALID_DROP    = 0;
  localparam int ERR_DATA_UNSTABLE = 1;
  localparam int ERR_STALL_TO      = 2;
  localparam int ERR_FRAMING       = 3;

  localparam int TUSER_VALID = 0;
  localparam int TUSER_HDR   = 1;
  localparam int TUSER_TAIL  = 2;

  typedef enum logic {IDLE, STALLED} stall_state_t;
  typedef enum logic {CLOSED, OPEN}  pkt_state_t;

  // LSB of a per-flit TUSER field; each field is FPW bits wide.
  function automatic int tuser_field_lsb(input int fpw, input int field);
    return field * fpw;
  endfunction

endpackage

// File: rtl/openhmc_axis_ch_monitor.sv
// Single-channel passive monitor: stall FSM, packet framing checker,
// saturating flit/packet counters and sticky error flags.
module openhmc_axis_ch_monitor
  import openhmc_mon_pkg::*;
#(
  parameter int FPW             = 4,
  parameter int DWIDTH          = FPW*128,
  parameter int NUM_DATA_BYTES  = FPW*16,
  parameter int STALL_LIMIT_LOG = 10,
  parameter int CNT_W           = 32
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      mon_enable,
  input  logic                      mon_clear,
  input  logic                      tvalid,
  input  logic                      tready,
  input  logic [DWIDTH-1:0]         tdata,
  input  logic [NUM_DATA_BYTES-1:0] tuser,
  output logic [3:0]                err_sticky,
  output logic [3:0]                err_next,
  output logic [CNT_W-1:0]          flit_cnt,
  output logic [CNT_W-1:0]          pkt_cnt,
  output logic                      pkt_open
);

  localparam int VLD_LSB  = tuser_field_lsb(FPW, TUSER_VALID);
  localparam int HDR_LSB  = tuser_field_lsb(FPW, TUSER_HDR);
  localparam int TAIL_LSB = tuser_field_lsb(FPW, TUSER_TAIL);
  localparam logic [STALL_LIMIT_LOG-1:0] STALL_MAX = '1;

  stall_state_t                stall_state_q, stall_state_d;
  pkt_state_t                  pkt_state_q, pkt_state_d;
  logic [STALL_LIMIT_LOG-1:0]  stall_cnt_q, stall_cnt_d;
  logic                        to_done_q, to_done_d;
  logic [DWIDTH-1:0]           cap_data_q, cap_data_d;
  logic [NUM_DATA_BYTES-1:0]   cap_user_q, cap_user_d;
  logic [CNT_W-1:0]            flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0]            pkt_cnt_q, pkt_cnt_d;
  logic [3:0]                  err_q, err_d, err_set;
  logic                        hs;
  logic [FPW-1:0]              fv, fh, ft;

  function automatic logic [CNT_W-1:0] popcnt(input logic [FPW-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < FPW; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign hs = tvalid & tready;
  assign fv = tuser[VLD_LSB  +: FPW];
  assign fh = tuser[HDR_LSB  +: FPW];
  assign ft = tuser[TAIL_LSB +: FPW];

  always_comb begin
    stall_state_d = stall_state_q;
    pkt_state_d   = pkt_state_q;
    stall_cnt_d   = stall_cnt_q;
    to_done_d     = to_done_q;
    cap_data_d    = cap_data_q;
    cap_user_d    = cap_user_q;
    flit_cnt_d    = flit_cnt_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_set       = '0;

    case (stall_state_q)
      IDLE: begin
        if (tvalid && !tready) begin
          stall_state_d = STALLED;
          cap_data_d    = tdata;
          cap_user_d    = tuser;
          stall_cnt_d   = '0;
          to_done_d     = 1'b0;
        end
      end
      default: begin
        // Re-capture after a change so one glitch is not reported every cycle.
        if (tvalid && (tdata != cap_data_q || tuser != cap_user_q)) begin
          err_set[ERR_DATA_UNSTABLE] = 1'b1;
          cap_data_d = tdata;
          cap_user_d = tuser;
        end
        if (hs) begin
          stall_state_d = IDLE;
        end else if (!tvalid) begin
          stall_state_d = IDLE;
          err_set[ERR_VALID_DROP] = 1'b1;
        end else begin
          if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + STALL_LIMIT_LOG'(1);
          if (stall_cnt_d == STALL_MAX && !to_done_q) begin
            err_set[ERR_STALL_TO] = 1'b1;
            to_done_d = 1'b1;
          end
        end
      end
    endcase

    for (int i = 0; i < FPW; i++) begin
      if (hs && fv[i]) begin
        if (pkt_state_d == CLOSED) begin
          if (fh[i] && !ft[i])     pkt_state_d = OPEN;
          else if (!fh[i])         err_set[ERR_FRAMING] = 1'b1;
        end else begin
          if (fh[i]) begin
            err_set[ERR_FRAMING] = 1'b1;
            pkt_state_d = ft[i] ? CLOSED : OPEN;
          end else if (ft[i]) begin
            pkt_state_d = CLOSED;
          end
        end
      end
    end

    if (hs && mon_enable) begin
      flit_cnt_d = sat_add(flit_cnt_q, popcnt(fv));
      pkt_cnt_d  = sat_add(pkt_cnt_q, popcnt(fv & ft));
    end
    err_d = mon_enable ? (err_q | err_set) : err_q;

    if (mon_clear) begin
      flit_cnt_d = '0;
      pkt_cnt_d  = '0;
      err_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      stall_state_q <= IDLE;
      pkt_state_q   <= CLOSED;
      stall_cnt_q   <= '0;
      to_done_q     <= 1'b0;
      cap_data_q    <= '0;
      cap_user_q    <= '0;
      flit_cnt_q    <= '0;
      pkt_cnt_q     <= '0;
      err_q         <= '0;
    end else begin
      stall_state_q <= stall_state_d;
      pkt_state_q   <= pkt_state_d;
      stall_cnt_q   <= stall_cnt_d;
      to_done_q     <= to_done_d;
      cap_data_q    <= cap_data_d;
      cap_user_q    <= cap_user_d;
      flit_cnt_q    <= flit_cnt_d;
      pkt_cnt_q     <= pkt_cnt_d;
      err_q         <= err_d;
    end
  end

  assign err_sticky = err_q;
  assign err_next   = err_d;
  assign flit_cnt   = flit_cnt_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign pkt_open   = (pkt_state_q == OPEN);

endmodule

// File: rtl/openhmc_axis_link_monitor.sv
// Multi-channel openHMC AXI4-Stream link monitor: one channel monitor per stream,
// plus a registered OR of every sticky error bit.
module openhmc_axis_link_monitor
  import openhmc_mon_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int FPW             = 4,
  parameter int DWIDTH          = FPW*128,
  parameter int NUM_DATA_BYTES  = FPW*16,
  parameter int STALL_LIMIT_LOG = 10,
  parameter int CNT_W           = 32
) (
  input  logic                             clk_hmc,
  input  logic                             res_n_hmc,
  input  logic                             mon_enable,
  input  logic                             mon_clear,
  input  logic [NUM_CH-1:0]                ch_tvalid,
  input  logic [NUM_CH-1:0]                ch_tready,
  input  logic [NUM_CH*DWIDTH-1:0]         ch_tdata,
  input  logic [NUM_CH*NUM_DATA_BYTES-1:0] ch_tuser,
  output logic [NUM_CH*4-1:0]              err_sticky,
  output logic                             err_any,
  output logic [NUM_CH*CNT_W-1:0]          flit_cnt,
  output logic [NUM_CH*CNT_W-1:0]          pkt_cnt,
  output logic [NUM_CH-1:0]                pkt_open
);

  logic [NUM_CH*4-1:0] err_next;
  logic                err_any_q, err_any_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    openhmc_axis_ch_monitor #(
      .FPW(FPW), .DWIDTH(DWIDTH), .NUM_DATA_BYTES(NUM_DATA_BYTES),
      .STALL_LIMIT_LOG(STALL_LIMIT_LOG), .CNT_W(CNT_W)
    ) u_ch (
      .clk        (clk_hmc),
      .res_n      (res_n_hmc),
      .mon_enable (mon_enable),
      .mon_clear  (mon_clear),
      .tvalid     (ch_tvalid[g]),
      .tready     (ch_tready[g]),
      .tdata      (ch_tdata[g*DWIDTH +: DWIDTH]),
      .tuser      (ch_tuser[g*NUM_DATA_BYTES +: NUM_DATA_BYTES]),
      .err_sticky (err_sticky[g*4 +: 4]),
      .err_next   (err_next[g*4 +: 4]),
      .flit_cnt   (flit_cnt[g*CNT_W +: CNT_W]),
      .pkt_cnt    (pkt_cnt[g*CNT_W +: CNT_W]),
      .pkt_open   (pkt_open[g])
    );
  end

  // Reduced from next-state so err_any lines up with err_sticky.
  assign err_any_d = |err_next;

  always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
    if (!res_n_hmc) err_any_q <= 1'b0;
    else            err_any_q <= err_any_d;
  end

  assign err_any = err_any_q;

endmodule

// File: tb/tb_openhmc_axis_link_monitor.sv
// Directed bench for openhmc_axis_link_monitor (NUM_CH=2, FPW=4, STALL_LIMIT_LOG=10).
module tb_openhmc_axis_link_monitor;

  localparam int NUM_CH = 2;
  localparam int FPW    = 4;
  localparam int DW     = FPW*128;
  localparam int NDB    = FPW*16;
  localparam int CW     = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mon_enable, mon_clear;
  logic [NUM_CH-1:0]     tvalid, tready;
  logic [NUM_CH*DW-1:0]  tdata;
  logic [NUM_CH*NDB-1:0] tuser;
  logic [NUM_CH*4-1:0]   err_sticky;
  logic                  err_any;
  logic [NUM_CH*CW-1:0]  flit_cnt, pkt_cnt;
  logic [NUM_CH-1:0]     pkt_open;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string          tag;
    logic [7:0]     err;
    logic           any;
    logic [CW-1:0]  f0, p0, f1, p1;
    logic [1:0]     po;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] dstall;

  openhmc_axis_link_monitor #(
    .NUM_CH(NUM_CH), .FPW(FPW), .DWIDTH(DW), .NUM_DATA_BYTES(NDB),
    .STALL_LIMIT_LOG(10), .CNT_W(CW)
  ) dut (
    .clk_hmc    (clk),
    .res_n_hmc  (rst_n),
    .mon_enable (mon_enable),
    .mon_clear  (mon_clear),
    .ch_tvalid  (tvalid),
    .ch_tready  (tready),
    .ch_tdata   (tdata),
    .ch_tuser   (tuser),
    .err_sticky (err_sticky),
    .err_any    (err_any),
    .flit_cnt   (flit_cnt),
    .pkt_cnt    (pkt_cnt),
    .pkt_open   (pkt_open)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int c, input logic v, input logic r,
                       input logic [3:0] fv, input logic [3:0] fh, input logic [3:0] ft,
                       input logic [DW-1:0] d);
    tvalid[c] = v;
    tready[c] = r;
    tdata[c*DW +: DW] = d;
    tuser[c*NDB +: NDB] = {{(NDB-12){1'b0}}, ft, fh, fv};
  endtask

  task automatic idle(input int c);
    drive(c, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, '0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic step(input string tag, input logic [7:0] err, input logic any,
                      input logic [CW-1:0] f0, input logic [CW-1:0] p0,
                      input logic [CW-1:0] f1, input logic [CW-1:0] p1, input logic [1:0] po);
    exp_t e;
    e.tag = tag; e.err = err; e.any = any;
    e.f0 = f0; e.p0 = p0; e.f1 = f1; e.p1 = p1; e.po = po;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({e.tag, ".err"},  {24'b0, err_sticky},       {24'b0, e.err});
    chk({e.tag, ".any"},  {31'b0, err_any},          {31'b0, e.any});
    chk({e.tag, ".f0"},   flit_cnt[0 +: CW],         e.f0);
    chk({e.tag, ".p0"},   pkt_cnt[0 +: CW],          e.p0);
    chk({e.tag, ".f1"},   flit_cnt[CW +: CW],        e.f1);
    chk({e.tag, ".p1"},   pkt_cnt[CW +: CW],         e.p1);
    chk({e.tag, ".open"}, {30'b0, pkt_open},         {30'b0, e.po});
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mon_enable = 1'b1; mon_clear = 1'b0;
    tvalid = '0; tready = '0; tdata = '0; tuser = '0;
    step("reset", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    rst_n = 1'b1;
    step("post_reset", 8'h00, 0, 0, 0, 0, 0, 2'b00);

    // 8 single-beat packets on channel 0
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1, 4'hF, 4'h1, 4'h8, rnd_data());
      step("t1_beat", 8'h00, 0, CW'(4*(i+1)), CW'(i+1), 0, 0, 2'b00);
    end

    // Stall three cycles, then drop TVALID
    dstall = rnd_data();
    drive(0, 1, 0, 4'hF, 4'h1, 4'h8, dstall);
    step("t2_stall1", 8'h00, 0, 32, 8, 0, 0, 2'b00);
    step("t2_stall2", 8'h00, 0, 32, 8, 0, 0, 2'b00);
    step("t2_stall3", 8'h00, 0, 32, 8, 0, 0, 2'b00);
    idle(0);
    step("t2_drop", 8'h01, 1, 32, 8, 0, 0, 2'b00);
    mon_clear = 1'b1;
    step("t2_clear", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    mon_clear = 1'b0;

    // Data changes in the 2nd stall cycle
    dstall = rnd_data();
    drive(0, 1, 0, 4'hF, 4'h1, 4'h8, dstall);
    step("t3_stall1", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    dstall[0] = ~dstall[0];
    drive(0, 1, 0, 4'hF, 4'h1, 4'h8, dstall);
    step("t3_unstable", 8'h02, 1, 0, 0, 0, 0, 2'b00);
    step("t3_stall3", 8'h02, 1, 0, 0, 0, 0, 2'b00);
    tready[0] = 1'b1;
    step("t3_accept", 8'h02, 1, 4, 1, 0, 0, 2'b00);
    idle(0);
    step("t3_idle", 8'h02, 1, 4, 1, 0, 0, 2'b00);

    // Long stall: timeout on the 1024th stalled cycle, not before
    drive(0, 1, 0, 4'hF, 4'h1, 4'h8, rnd_data());
    run(1022);
    step("t3_stall1023", 8'h02, 1, 4, 1, 0, 0, 2'b00);
    step("t3_stall1024", 8'h06, 1, 4, 1, 0, 0, 2'b00);
    step("t3_stall1025", 8'h06, 1, 4, 1, 0, 0, 2'b00);
    tready[0] = 1'b1;
    step("t3_release", 8'h06, 1, 8, 2, 0, 0, 2'b00);
    idle(0);
    mon_clear = 1'b1;
    step("t3_clear", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    mon_clear = 1'b0;

    // Two packets in one beat, then a beat with no header
    drive(0, 1, 1, 4'hF, 4'b0101, 4'b1010, rnd_data());
    step("t4_two_pkts", 8'h00, 0, 4, 2, 0, 0, 2'b00);
    drive(0, 1, 1, 4'hF, 4'h0, 4'h0, rnd_data());
    step("t4_framing", 8'h08, 1, 8, 2, 0, 0, 2'b00);
    idle(0);
    mon_clear = 1'b1;
    step("t4_clear", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    mon_clear = 1'b0;

    // Clear in the middle of a packet
    drive(0, 1, 1, 4'hF, 4'h1, 4'h0, rnd_data());
    step("t5_hdr", 8'h00, 0, 4, 0, 0, 0, 2'b01);
    idle(0);
    mon_clear = 1'b1;
    step("t5_clear", 8'h00, 0, 0, 0, 0, 0, 2'b01);
    mon_clear = 1'b0;
    drive(0, 1, 1, 4'h1, 4'h0, 4'h1, rnd_data());
    step("t5_tail", 8'h00, 0, 1, 1, 0, 0, 2'b00);

    // Disabled monitor keeps tracking framing but freezes counts
    mon_enable = 1'b0;
    drive(0, 1, 1, 4'hF, 4'h1, 4'h0, rnd_data());
    step("t5_dis_hdr", 8'h00, 0, 1, 1, 0, 0, 2'b01);
    mon_enable = 1'b1;
    drive(0, 1, 1, 4'h3, 4'h0, 4'h2, rnd_data());
    step("t5_en_tail", 8'h00, 0, 3, 2, 0, 0, 2'b00);

    // Channel 0 errors while channel 1 runs clean
    drive(0, 1, 0, 4'hF, 4'h1, 4'h8, rnd_data());
    drive(1, 1, 1, 4'hF, 4'h1, 4'h8, rnd_data());
    step("t6_a", 8'h00, 0, 3, 2, 4, 1, 2'b00);
    idle(0);
    drive(1, 1, 1, 4'hF, 4'h1, 4'h8, rnd_data());
    step("t6_drop", 8'h01, 1, 3, 2, 8, 2, 2'b00);
    drive(0, 1, 1, 4'hF, 4'h0, 4'h0, rnd_data());
    drive(1, 1, 1, 4'hF, 4'h1, 4'h8, rnd_data());
    step("t6_framing", 8'h09, 1, 7, 2, 12, 3, 2'b00);
    drive(0, 1, 1, 4'hF, 4'h0, 4'h0, rnd_data());
    drive(1, 1, 1, 4'hF, 4'h1, 4'h8, rnd_data());
    mon_clear = 1'b1;
    step("t6_clear_hs", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    mon_clear = 1'b0;
    idle(0);
    step("t6_resume", 8'h00, 0, 0, 0, 4, 1, 2'b00);
    idle(1);

    // Asynchronous reset in the middle of a packet
    drive(0, 1, 1, 4'hF, 4'h1, 4'h0, rnd_data());
    step("t7_hdr", 8'h00, 0, 4, 0, 4, 1, 2'b01);
    idle(0);
    rst_n = 1'b0;
    #1;
    chk("t7_async_open", {30'b0, pkt_open}, 32'd0);
    chk("t7_async_f1", flit_cnt[CW +: CW], 32'd0);
    step("t7_in_reset", 8'h00, 0, 0, 0, 0, 0, 2'b00);
    rst_n = 1'b1;
    step("t7_release", 8'h00, 0, 0, 0, 0, 0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
